// File: rtl/lfsr_core_if.sv
// Seed/enable control and state/done status bundle for lfsr_core.
// master drives the controls; slave (the LFSR) drives the status.
interface lfsr_core_if #(
    parameter int NUM_BITS = 4
);
    logic                i_Enable;
    logic                i_Seed_DV;
    logic [NUM_BITS-1:0] i_Seed_Data;
    logic [NUM_BITS-1:0] o_LFSR_Data;
    logic                o_LFSR_Done;

    modport master (
        output i_Enable,
        output i_Seed_DV,
        output i_Seed_Data,
        input  o_LFSR_Data,
        input  o_LFSR_Done
    );

    modport slave (
        input  i_Enable,
        input  i_Seed_DV,
        input  i_Seed_Data,
        output o_LFSR_Data,
        output o_LFSR_Done
    );
endinterface

// File: rtl/lfsr_core.sv
// Maximal-length Fibonacci LFSR, XNOR feedback, loadable seed.
// o_LFSR_Done compares the live state with the live seed input.
module lfsr_core #(
    parameter int NUM_BITS = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    lfsr_core_if.slave  bus
);

    if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
        $error("lfsr_core: NUM_BITS must be in 3..32");
    end

    function automatic logic [31:0] f_bit(input int unsigned p);
        return 32'd1 << (p - 1);
    endfunction

    // Tap positions are 1-based with the MSB at position NUM_BITS.
    function automatic logic [31:0] f_taps(input int unsigned n);
        logic [31:0] m;
        m = '0;
        case (n)
            3:  m = f_bit(3)  | f_bit(2);
            4:  m = f_bit(4)  | f_bit(3);
            5:  m = f_bit(5)  | f_bit(3);
            6:  m = f_bit(6)  | f_bit(5);
            7:  m = f_bit(7)  | f_bit(6);
            8:  m = f_bit(8)  | f_bit(6)  | f_bit(5)  | f_bit(4);
            9:  m = f_bit(9)  | f_bit(5);
            10: m = f_bit(10) | f_bit(7);
            11: m = f_bit(11) | f_bit(9);
            12: m = f_bit(12) | f_bit(6)  | f_bit(4)  | f_bit(1);
            13: m = f_bit(13) | f_bit(4)  | f_bit(3)  | f_bit(1);
            14: m = f_bit(14) | f_bit(5)  | f_bit(3)  | f_bit(1);
            15: m = f_bit(15) | f_bit(14);
            16: m = f_bit(16) | f_bit(15) | f_bit(13) | f_bit(4);
            17: m = f_bit(17) | f_bit(14);
            18: m = f_bit(18) | f_bit(11);
            19: m = f_bit(19) | f_bit(6)  | f_bit(2)  | f_bit(1);
            20: m = f_bit(20) | f_bit(17);
            21: m = f_bit(21) | f_bit(19);
            22: m = f_bit(22) | f_bit(21);
            23: m = f_bit(23) | f_bit(18);
            24: m = f_bit(24) | f_bit(23) | f_bit(22) | f_bit(17);
            25: m = f_bit(25) | f_bit(22);
            26: m = f_bit(26) | f_bit(6)  | f_bit(2)  | f_bit(1);
            27: m = f_bit(27) | f_bit(5)  | f_bit(2)  | f_bit(1);
            28: m = f_bit(28) | f_bit(25);
            29: m = f_bit(29) | f_bit(27);
            30: m = f_bit(30) | f_bit(6)  | f_bit(4)  | f_bit(1);
            31: m = f_bit(31) | f_bit(28);
            32: m = f_bit(32) | f_bit(22) | f_bit(2)  | f_bit(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [31:0] TAPS = f_taps(NUM_BITS);

    logic [NUM_BITS-1:0] r_lfsr;
    logic                w_fb;

    // XNOR feedback: all-zeros advances, all-ones is the lock-up state.
    assign w_fb = ~^(r_lfsr & TAPS[NUM_BITS-1:0]);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_lfsr <= '0;
        end else if (bus.i_Enable) begin
            if (bus.i_Seed_DV) begin
                r_lfsr <= bus.i_Seed_Data;
            end else begin
                r_lfsr <= {r_lfsr[NUM_BITS-2:0], w_fb};
            end
        end
    end

    assign bus.o_LFSR_Data = r_lfsr;
    assign bus.o_LFSR_Done = (r_lfsr == bus.i_Seed_Data);

endmodule

// File: tb/tb_lfsr_core.sv
// Directed self-checking bench for lfsr_core at NUM_BITS=4 and NUM_BITS=8.
module tb_lfsr_core;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lfsr_core_if #(.NUM_BITS(4)) bus4 ();
    lfsr_core_if #(.NUM_BITS(8)) bus8 ();

    lfsr_core #(.NUM_BITS(4)) u_dut4 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus4.slave)
    );

    lfsr_core #(.NUM_BITS(8)) u_dut8 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.i_Enable = 1'b0; bus4.i_Seed_DV = 1'b0; bus4.i_Seed_Data = 4'h8;
        bus8.i_Enable = 1'b0; bus8.i_Seed_DV = 1'b0; bus8.i_Seed_Data = 8'h01;
        step();
        step();
        checks++;
        if (bus4.o_LFSR_Data !== 4'h0) begin
            errors++;
            $display("FAIL reset_data4 got %h exp %h", bus4.o_LFSR_Data, 4'h0);
        end
        checks++;
        if (bus4.o_LFSR_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done4 got %b exp %b", bus4.o_LFSR_Done, 1'b0);
        end
        checks++;
        if (bus8.o_LFSR_Data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data8 got %h exp %h", bus8.o_LFSR_Data, 8'h00);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus4.o_LFSR_Data !== 4'h0) begin
            errors++;
            $display("FAIL idle_hold got %h exp %h", bus4.o_LFSR_Data, 4'h0);
        end
    endtask

    task automatic test_seed_live();
        bus4.i_Seed_Data = 4'h0;
        #1;
        checks++;
        if (bus4.o_LFSR_Done !== 1'b1) begin
            errors++;
            $display("FAIL seed_live_hit got %b exp %b", bus4.o_LFSR_Done, 1'b1);
        end
        bus4.i_Seed_Data = 4'h8;
        #1;
        checks++;
        if (bus4.o_LFSR_Done !== 1'b0) begin
            errors++;
            $display("FAIL seed_live_miss got %b exp %b", bus4.o_LFSR_Done, 1'b0);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq [16];
        seq = '{4'h8, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
        bus4.i_Seed_Data = 4'h8;
        bus4.i_Seed_DV   = 1'b1;
        bus4.i_Enable    = 1'b1;
        step();
        bus4.i_Seed_DV   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus4.o_LFSR_Data !== seq[i]) begin
                errors++;
                $display("FAIL seq4[%0d] got %h exp %h", i, bus4.o_LFSR_Data, seq[i]);
            end
            checks++;
            if (bus4.o_LFSR_Done !== (seq[i] == 4'h8)) begin
                errors++;
                $display("FAIL done4[%0d] got %b exp %b", i, bus4.o_LFSR_Done, (seq[i] == 4'h8));
            end
            if (i < 15) step();
        end
    endtask

    task automatic test_hold();
        // Enters at state 8; advance to 3, then freeze.
        step(); step(); step();
        bus4.i_Enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus4.o_LFSR_Data !== 4'h3) begin
                errors++;
                $display("FAIL hold[%0d] got %h exp %h", i, bus4.o_LFSR_Data, 4'h3);
            end
        end
        bus4.i_Enable = 1'b1;
        step();
        checks++;
        if (bus4.o_LFSR_Data !== 4'h7) begin
            errors++;
            $display("FAIL resume0 got %h exp %h", bus4.o_LFSR_Data, 4'h7);
        end
        step();
        checks++;
        if (bus4.o_LFSR_Data !== 4'hE) begin
            errors++;
            $display("FAIL resume1 got %h exp %h", bus4.o_LFSR_Data, 4'hE);
        end
    endtask

    task automatic test_dv_ignored();
        bus4.i_Enable    = 1'b0;
        bus4.i_Seed_Data = 4'h5;
        bus4.i_Seed_DV   = 1'b1;
        step();
        bus4.i_Seed_DV   = 1'b0;
        checks++;
        if (bus4.o_LFSR_Data !== 4'hE) begin
            errors++;
            $display("FAIL dv_ignored got %h exp %h", bus4.o_LFSR_Data, 4'hE);
        end
        bus4.i_Seed_Data = 4'h8;
        bus4.i_Enable    = 1'b1;
        step();
        checks++;
        if (bus4.o_LFSR_Data !== 4'hD) begin
            errors++;
            $display("FAIL dv_ignored_next got %h exp %h", bus4.o_LFSR_Data, 4'hD);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.o_LFSR_Data !== 4'h0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", bus4.o_LFSR_Data, 4'h0);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus4.o_LFSR_Data !== 4'h1) begin
            errors++;
            $display("FAIL post_reset0 got %h exp %h", bus4.o_LFSR_Data, 4'h1);
        end
        step();
        checks++;
        if (bus4.o_LFSR_Data !== 4'h3) begin
            errors++;
            $display("FAIL post_reset1 got %h exp %h", bus4.o_LFSR_Data, 4'h3);
        end
    endtask

    task automatic test_lockup();
        bus4.i_Seed_Data = 4'hF;
        bus4.i_Seed_DV   = 1'b1;
        bus4.i_Enable    = 1'b1;
        step();
        bus4.i_Seed_DV   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus4.o_LFSR_Data !== 4'hF || bus4.o_LFSR_Done !== 1'b1) begin
                errors++;
                $display("FAIL lockup[%0d] got %h/%b exp %h/%b", i,
                         bus4.o_LFSR_Data, bus4.o_LFSR_Done, 4'hF, 1'b1);
            end
            step();
        end
        bus4.i_Enable = 1'b0;
    endtask

    task automatic test_period8();
        int          seen [256];
        int          done_t [$];
        int          bad_done;
        logic [7:0]  head [5];
        head = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
        for (int i = 0; i < 256; i++) seen[i] = 0;
        bad_done = 0;
        bus8.i_Seed_Data = 8'h01;
        bus8.i_Seed_DV   = 1'b1;
        bus8.i_Enable    = 1'b1;
        step();
        bus8.i_Seed_DV   = 1'b0;
        for (int t = 0; t < 600; t++) begin
            if (t < 5) begin
                checks++;
                if (bus8.o_LFSR_Data !== head[t]) begin
                    errors++;
                    $display("FAIL seq8[%0d] got %h exp %h", t, bus8.o_LFSR_Data, head[t]);
                end
            end
            if (t < 255) seen[bus8.o_LFSR_Data]++;
            if (bus8.o_LFSR_Done === 1'b1) done_t.push_back(t);
            if (bus8.o_LFSR_Done !== (bus8.o_LFSR_Data == 8'h01)) bad_done++;
            step();
        end
        for (int v = 0; v < 256; v++) begin
            checks++;
            if (seen[v] != ((v == 255) ? 0 : 1)) begin
                errors++;
                $display("FAIL coverage8[%0d] got %0d exp %0d", v, seen[v], (v == 255) ? 0 : 1);
            end
        end
        checks++;
        if (bad_done != 0) begin
            errors++;
            $display("FAIL done8_consistency got %0d exp %0d", bad_done, 0);
        end
        checks++;
        if (done_t.size() != 3) begin
            errors++;
            $display("FAIL done8_count got %0d exp %0d", done_t.size(), 3);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (done_t[k] != 255 * k) begin
                    errors++;
                    $display("FAIL done8_time[%0d] got %0d exp %0d", k, done_t[k], 255 * k);
                end
            end
        end
        bus8.i_Enable = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_seed_live();
        test_sequence();
        test_hold();
        test_dv_ignored();
        test_async_reset();
        test_lockup();
        test_period8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
